light_uart_rx: RTL and testbench

Synthesizable device-side UART receiver, the far end of the LightUart line.
- Deserializes 8N1 frames (one or more stop bits) from `rxd` using 16x oversampling, with bit time = dbr<<4 clocks.
- Buffers received characters in a FIFO popped with a valid/ready handshake.
- Drives active-low `rts_n` back to the transactor's `cts` input for flow control.
- Sits between the UART pad and the DUT's host-bus register block.

---
 rtl/light_uart_pkg.sv | 23 ++
 rtl/light_uart_rx_fifo.sv | 58 +++++
 rtl/light_uart_rx.sv | 165 ++++++++++++++++
 tb/tb_light_uart_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/light_uart_pkg.sv
// Shared constants, state encoding and helpers for the LightUart receiver.
package light_uart_pkg;

   localparam int CHAR_WIDTH  = 8;
   localparam int OVERSAMPLE  = 16;
   localparam int SAMPLE_TICK = 7;
   // Wide enough for the last stop-bit tick (151, or 152 with voting)
   localparam int TICK_W      = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_e;

   // 2-of-3 vote used for noise-tolerant bit sampling
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/light_uart_rx_fifo.sv
// Receive character FIFO with a registered head; push and pop may coincide,
// including when full.
module light_uart_rx_fifo
   import light_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [CHAR_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count,
   output logic [CHAR_WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [CHAR_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      rd_ptr_nxt;
   logic                  do_push;
   logic                  do_pop;

   assign empty      = (count == '0);
   assign full       = (count == CNT_W'(FIFO_DEPTH));
   assign do_pop     = pop && !empty;
   // A full FIFO still accepts a push when a pop frees a slot in the same cycle
   assign do_push    = push && (!full || do_pop);
   assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);

   // Character storage, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers, occupancy and the registered head character
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         head   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr <= rd_ptr_nxt;
         count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         // When nothing older remains, the incoming character becomes the head
         if ((count == CNT_W'(do_pop)) && do_push) head <= push_data;
         else if (count > CNT_W'(do_pop))          head <= mem[rd_ptr_nxt];
      end
   end

endmodule

// File: rtl/light_uart_rx.sv
// LightUart device-side receiver: 8N1 deserializer with 16x oversampling,
// receive FIFO and rts_n flow control.
// Optional: define LIGHT_UART_RX_MAJORITY_EN for 2-of-3 voting around each
// sample point (decisions move one tick later).
module light_uart_rx
   import light_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int RTS_MARGIN = 2,
   parameter int DBR_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         rxd,
   input  logic [DBR_WIDTH-1:0]         dbr,
   output logic                         rx_valid,
   output logic [CHAR_WIDTH-1:0]        rx_data,
   input  logic                         rx_ready,
   output logic                         rts_n,
   output logic                         frame_err,
   output logic                         overrun,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef LIGHT_UART_RX_MAJORITY_EN
   localparam int DEC_OFF = 1;
`else
   localparam int DEC_OFF = 0;
`endif

   localparam logic [TICK_W-1:0] START_TICK = TICK_W'(SAMPLE_TICK + DEC_OFF);
   localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(SAMPLE_TICK + DEC_OFF + OVERSAMPLE * CHAR_WIDTH);
   localparam logic [TICK_W-1:0] STOP_TICK  = TICK_W'(SAMPLE_TICK + DEC_OFF + OVERSAMPLE * (CHAR_WIDTH + 1));
   localparam logic [3:0]        PHASE      = 4'(SAMPLE_TICK + DEC_OFF);

   rx_state_e             state, state_nxt;
   logic                  sync_p0, rxs;
   logic [DBR_WIDTH-1:0]  dbr_l, pre_cnt;
   logic [TICK_W-1:0]     tick_cnt;
   logic                  tick, frame_start, bit_val;
   logic                  data_smp, push, ferr_set, ovr_set;
   logic [CHAR_WIDTH-1:0] shreg;
   logic                  fifo_full, fifo_empty;

   // Two-flop synchronizer, preset to the idle-high line level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_p0 <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         sync_p0 <= rxd;
         rxs     <= sync_p0;
      end
   end

   assign frame_start = (state == IDLE) && !rxs;
   assign tick        = (state != IDLE) && (pre_cnt == dbr_l - DBR_WIDTH'(1));

   // Prescaler and tick counter, restarted and divisor latched at each frame start
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dbr_l    <= DBR_WIDTH'(1);
         pre_cnt  <= '0;
         tick_cnt <= '0;
      end else if (frame_start) begin
         dbr_l    <= (dbr == '0) ? DBR_WIDTH'(1) : dbr;
         pre_cnt  <= '0;
         tick_cnt <= '0;
      end else if (tick) begin
         pre_cnt  <= '0;
         tick_cnt <= tick_cnt + TICK_W'(1);
      end else if (state != IDLE) begin
         pre_cnt  <= pre_cnt + DBR_WIDTH'(1);
      end
   end

`ifdef LIGHT_UART_RX_MAJORITY_EN
   logic hist_p0, hist_p1;

   // Line level at the two previous ticks, feeding the vote at the current tick
   always_ff @(posedge clk) begin
      if (tick) begin
         hist_p0 <= rxs;
         hist_p1 <= hist_p0;
      end
   end

   assign bit_val = majority3(hist_p1, hist_p0, rxs);
`else
   assign bit_val = rxs;
`endif

   // Data bits shift in LSB first at each data sample point
   always_ff @(posedge clk) begin
      if (data_smp) shreg <= {bit_val, shreg[CHAR_WIDTH-1:1]};
   end

   // Frame sequencing: start verify, eight data samples, stop check, break wait
   always_comb begin
      state_nxt = state;
      data_smp  = 1'b0;
      push      = 1'b0;
      ferr_set  = 1'b0;
      ovr_set   = 1'b0;
      unique case (state)
         IDLE:  if (!rxs) state_nxt = START;
         START: if (tick && (tick_cnt == START_TICK)) state_nxt = bit_val ? IDLE : DATA;
         DATA: begin
            if (tick && (tick_cnt[3:0] == PHASE)) begin
               data_smp = 1'b1;
               if (tick_cnt == LAST_TICK) state_nxt = STOP;
            end
         end
         STOP: begin
            if (tick && (tick_cnt == STOP_TICK)) begin
               if (!bit_val) begin
                  ferr_set  = 1'b1;
                  state_nxt = BREAK;
               end else begin
                  state_nxt = IDLE;
                  // Full FIFO implies rx_valid, so rx_ready alone signals a pop
                  if (fifo_full && !rx_ready) ovr_set = 1'b1;
                  else                        push    = 1'b1;
               end
            end
         end
         BREAK: if (rxs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register, one-cycle error pulses and registered flow control
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         rts_n     <= 1'b1;
      end else begin
         state     <= state_nxt;
         frame_err <= ferr_set;
         overrun   <= ovr_set;
         rts_n     <= (fifo_count >= CNT_W'(FIFO_DEPTH - RTS_MARGIN));
      end
   end

   light_uart_rx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (shreg),
      .pop       (rx_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (rx_data)
   );

   assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_light_uart_rx.sv
// Scoreboard bench for light_uart_rx: stimulus pushes expected characters,
// a negedge monitor pops and compares on every rx_valid && rx_ready.
module tb_light_uart_rx;

   localparam int FIFO_DEPTH = 8;
   localparam int RTS_MARGIN = 2;
   localparam int DBR_WIDTH  = 16;
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

`ifdef LIGHT_UART_RX_MAJORITY_EN
   localparam int DEC_OFF = 1;
`else
   localparam int DEC_OFF = 0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 rxd;
   logic                 rx_ready;
   logic [DBR_WIDTH-1:0] dbr;
   logic                 rx_valid;
   logic [7:0]           rx_data;
   logic                 rts_n;
   logic                 frame_err;
   logic                 overrun;
   logic [CNT_W-1:0]     fifo_count;

   int         checks = 0;
   int         errors = 0;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   logic [7:0] exp_q[$];

   light_uart_rx #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .RTS_MARGIN (RTS_MARGIN),
      .DBR_WIDTH  (DBR_WIDTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rxd        (rxd),
      .dbr        (dbr),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .rts_n      (rts_n),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: count flag pulses, compare every popped character with the scoreboard
   always @(negedge clk) begin
      logic [7:0] e;
      if (rst_n === 1'b1) begin
         if (frame_err === 1'b1) fe_cnt++;
         if (overrun === 1'b1)   ov_cnt++;
         if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_char: got %02h, scoreboard empty", rx_data);
            end else begin
               e = exp_q.pop_front();
               check("rx_data", 32'(rx_data), 32'(e));
            end
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input int nstop);
      int bt;
      bt = 16 * int'(dbr);
      @(posedge clk);
      #1 rxd = 1'b0;
      hold(bt);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         hold(bt);
      end
      rxd = 1'b1;
      hold(bt * nstop);
   endtask

   initial begin
      int fe0, ov0;
      logic [7:0] bytes [9];
      bytes[0] = 8'h01; bytes[1] = 8'h23; bytes[2] = 8'h45; bytes[3] = 8'h67; bytes[4] = 8'h89;
      bytes[5] = 8'hAB; bytes[6] = 8'hCD; bytes[7] = 8'hEF; bytes[8] = 8'h96;

      rst_n = 1'b0; rxd = 1'b1; rx_ready = 1'b0; dbr = 16'd1;
      hold(3);
      check("reset_rx_valid", 32'(rx_valid), 0);
      check("reset_rx_data", 32'(rx_data), 0);
      check("reset_frame_err", 32'(frame_err), 0);
      check("reset_overrun", 32'(overrun), 0);
      check("reset_fifo_count", 32'(fifo_count), 0);
      check("reset_rts_n", 32'(rts_n), 1);
      rst_n = 1'b1;
      hold(1);
      check("rts_n_after_reset", 32'(rts_n), 0);

      // Single character, three stop bits
      fe0 = fe_cnt; ov0 = ov_cnt;
      rx_ready = 1'b1;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 3);
      hold(5);
      check("single_sb_empty", 32'(exp_q.size()), 0);
      check("single_no_ferr", 32'(fe_cnt - fe0), 0);
      check("single_no_ovr", 32'(ov_cnt - ov0), 0);

      // Back-to-back bytes at dbr=4, consumer stalled
      rx_ready = 1'b0; dbr = 16'd4;
      exp_q.push_back(8'h00); send_byte(8'h00, 1);
      exp_q.push_back(8'hFF); send_byte(8'hFF, 1);
      exp_q.push_back(8'h5A); send_byte(8'h5A, 1);
      hold(2);
      check("b2b_count", 32'(fifo_count), 3);
      check("b2b_rts_n", 32'(rts_n), 0);
      rx_ready = 1'b1;
      hold(10);
      check("b2b_sb_empty", 32'(exp_q.size()), 0);
      check("b2b_drained", 32'(fifo_count), 0);

      // False start at dbr=2, then a good frame proves the receiver is idle again
      dbr = 16'd2; fe0 = fe_cnt;
      @(posedge clk);
      #1 rxd = 1'b0;
      hold(6);
      rxd = 1'b1;
      hold(100);
      check("false_start_count", 32'(fifo_count), 0);
      check("false_start_valid", 32'(rx_valid), 0);
      check("false_start_ferr", 32'(fe_cnt - fe0), 0);
      exp_q.push_back(8'h3C);
      send_byte(8'h3C, 1);
      hold(5);
      check("after_false_sb_empty", 32'(exp_q.size()), 0);

      // Framing error: stop held low for 40 bit times, then a valid 0x33
      dbr = 16'd1; fe0 = fe_cnt; ov0 = ov_cnt;
      @(posedge clk);
      #1 rxd = 1'b0;
      hold(16 * 9 + 16 * 40);
      rxd = 1'b1;
      hold(32);
      exp_q.push_back(8'h33);
      send_byte(8'h33, 2);
      hold(5);
      check("ferr_pulses", 32'(fe_cnt - fe0), 1);
      check("ferr_no_ovr", 32'(ov_cnt - ov0), 0);
      check("ferr_sb_empty", 32'(exp_q.size()), 0);

      // Flow control and overrun with the consumer stalled
      rx_ready = 1'b0; ov0 = ov_cnt;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) exp_q.push_back(bytes[i]);
         send_byte(bytes[i], 1);
         if (i == 4) check("rts_n_at_5", 32'(rts_n), 0);
         if (i == 5) check("rts_n_at_6", 32'(rts_n), 1);
      end
      hold(2);
      check("ovr_pulses", 32'(ov_cnt - ov0), 1);
      check("ovr_count_full", 32'(fifo_count), 8);
      rx_ready = 1'b1;
      hold(12);
      rx_ready = 1'b0;
      check("ovr_sb_empty", 32'(exp_q.size()), 0);
      check("ovr_drained", 32'(fifo_count), 0);

      // Same fill, but a single pop coincides with the ninth push
      ov0 = ov_cnt;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(bytes[i]);
         send_byte(bytes[i], 1);
      end
      exp_q.push_back(bytes[8]);
      fork
         send_byte(bytes[8], 1);
         begin
            @(posedge clk);
            repeat (154 + DEC_OFF) @(posedge clk);
            #1 rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
         end
      join
      hold(2);
      check("coincide_no_ovr", 32'(ov_cnt - ov0), 0);
      check("coincide_count", 32'(fifo_count), 8);
      rx_ready = 1'b1;
      hold(12);
      check("coincide_sb_empty", 32'(exp_q.size()), 0);

      // Reset during DATA with one character already buffered
      rx_ready = 1'b0; fe0 = fe_cnt; ov0 = ov_cnt;
      exp_q.push_back(8'h11);
      send_byte(8'h11, 1);
      check("pre_reset_count", 32'(fifo_count), 1);
      fork
         send_byte(8'hF0, 2);
         begin
            @(posedge clk);
            repeat (89) @(posedge clk);
            #1 rst_n = 1'b0;
            @(posedge clk);
            #1;
            check("midrst_rx_valid", 32'(rx_valid), 0);
            check("midrst_rx_data", 32'(rx_data), 0);
            check("midrst_count", 32'(fifo_count), 0);
            check("midrst_rts_n", 32'(rts_n), 1);
            check("midrst_flags", 32'({frame_err, overrun}), 0);
            exp_q.delete();
            rst_n = 1'b1;
         end
      join
      hold(5);
      check("midrst_no_char", 32'(fifo_count), 0);
      check("midrst_no_ferr", 32'(fe_cnt - fe0), 0);
      check("midrst_no_ovr", 32'(ov_cnt - ov0), 0);
      rx_ready = 1'b1;
      exp_q.push_back(8'h7E);
      send_byte(8'h7E, 1);
      hold(10);
      check("midrst_7e_received", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
